// File: rtl/memory_stage.sv
// Memory pipeline stage: holds one instruction from execute, checks load/store alignment,
// issues the byte-strobed request on the data bus and hands the instruction to writeback.
module memory_stage #(
    parameter int CTRL_W = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [31:0]       pc_i,
    input  logic [31:0]       inst_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic              mem_rd_i,
    input  logic              mem_wr_i,
    input  logic [1:0]        mem_size_i,
    input  logic [1:0]        mem_lr_i,
    input  logic [31:0]       eaddr_i,
    input  logic [31:0]       rdata2_i,
    input  logic [31:0]       result_i,
    input  logic [4:0]        waddr_i,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [31:0]       data_addr,
    output logic [3:0]        data_wstrb,
    output logic [31:0]       data_wdata,
    input  logic              data_addr_ok,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [31:0]       pc_o,
    output logic [31:0]       inst_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [31:0]       eaddr_o,
    output logic [31:0]       rdata2_o,
    output logic [31:0]       result_o,
    output logic [4:0]        waddr_o,
    output logic              adel_o,
    output logic              ades_o,
    output logic [31:0]       perfcnt_addr_waitack,
    output logic [1:0]        state_o
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_REQ   = 2'd1,
        S_PASS  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       pc_q, inst_q, eaddr_q, rdata2_q, result_q, perf_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [4:0]        waddr_q;
    logic              rd_q, wr_q, adel_q, ades_q;
    logic [1:0]        size_q, lr_q;

    logic              in_mem, in_fault, accept;
    logic [1:0]        lane;
    logic [4:0]        swl_shamt, swr_shamt;

    assign in_mem = mem_rd_i | mem_wr_i;

    // LWL/LWR/SWL/SWR address whole words, so they never fault.
    always_comb begin
        in_fault = 1'b0;
        if (in_mem && mem_lr_i == 2'b00) begin
            case (mem_size_i)
                2'd2:    in_fault = |eaddr_i[1:0];
                2'd1:    in_fault = eaddr_i[0];
                default: in_fault = 1'b0;
            endcase
        end
    end

    // Requests are only raised while WB is free, which keeps one transaction in flight.
    assign data_req = (state_q == S_REQ) && ready_i && !flush_i;
    assign valid_o  = !flush_i && ((state_q == S_PASS) || (data_req && data_addr_ok));
    assign ready_o  = (state_q == S_EMPTY) || (valid_o && ready_i);
    assign accept   = valid_i && ready_o && !flush_i;

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = S_EMPTY;
        end else if (ready_o) begin
            if (valid_i) state_d = (in_mem && !in_fault) ? S_REQ : S_PASS;
            else         state_d = S_EMPTY;
        end
    end

    assign lane      = eaddr_q[1:0];
    assign swl_shamt = {2'd3 - lane, 3'b000};
    assign swr_shamt = {lane, 3'b000};

    always_comb begin
        data_addr  = eaddr_q;
        data_size  = size_q;
        data_wstrb = 4'b0000;
        data_wdata = rdata2_q;
        if (lr_q != 2'b00) begin
            data_addr = {eaddr_q[31:2], 2'b00};
            data_size = 2'd2;
        end
        if (wr_q) begin
            case (lr_q)
                2'b01: begin
                    data_wstrb = 4'b1111 >> (2'd3 - lane);
                    data_wdata = rdata2_q >> swl_shamt;
                end
                2'b10: begin
                    data_wstrb = 4'b1111 << lane;
                    data_wdata = rdata2_q << swr_shamt;
                end
                default: begin
                    case (size_q)
                        2'd0: begin
                            data_wstrb = 4'b0001 << lane;
                            data_wdata = {4{rdata2_q[7:0]}};
                        end
                        2'd1: begin
                            data_wstrb = 4'b0011 << lane;
                            data_wdata = {2{rdata2_q[15:0]}};
                        end
                        default: begin
                            data_wstrb = 4'b1111;
                            data_wdata = rdata2_q;
                        end
                    endcase
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= S_EMPTY;
            pc_q     <= '0;
            inst_q   <= '0;
            ctrl_q   <= '0;
            eaddr_q  <= '0;
            rdata2_q <= '0;
            result_q <= '0;
            waddr_q  <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            size_q   <= '0;
            lr_q     <= '0;
            adel_q   <= 1'b0;
            ades_q   <= 1'b0;
            perf_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                pc_q     <= pc_i;
                inst_q   <= inst_i;
                ctrl_q   <= ctrl_i;
                eaddr_q  <= eaddr_i;
                rdata2_q <= rdata2_i;
                result_q <= result_i;
                waddr_q  <= waddr_i;
                rd_q     <= mem_rd_i;
                wr_q     <= mem_wr_i;
                size_q   <= mem_size_i;
                lr_q     <= mem_lr_i;
                adel_q   <= in_fault & mem_rd_i;
                ades_q   <= in_fault & mem_wr_i;
            end
            if (data_req && !data_addr_ok) perf_q <= perf_q + 32'd1;
        end
    end

    assign data_wr              = wr_q;
    assign pc_o                 = pc_q;
    assign inst_o               = inst_q;
    assign ctrl_o               = ctrl_q;
    assign eaddr_o              = eaddr_q;
    assign rdata2_o             = rdata2_q;
    assign result_o             = result_q;
    assign waddr_o              = waddr_q;
    assign adel_o               = adel_q;
    assign ades_o               = ades_q;
    assign perfcnt_addr_waitack = perf_q;
    assign state_o              = state_q;

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed cases plus random traffic against a behavioural
// model of the held instruction, the bus request it produces and the WB hand-off.
module tb_memory_stage;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic          fl, vi, rdy, aok, rd_in, wr_in;
    logic [31:0]   pc_in, inst_in, ea_in, rt_in, res_in;
    logic [CW-1:0] ctrl_in;
    logic [1:0]    size_in, lr_in;
    logic [4:0]    wa_in;

    logic          ready_o, data_req, data_wr, valid_o, adel_o, ades_o;
    logic [1:0]    data_size, state_o;
    logic [31:0]   data_addr, data_wdata, pc_o, inst_o, eaddr_o, rdata2_o, result_o, perf;
    logic [3:0]    data_wstrb;
    logic [CW-1:0] ctrl_o;
    logic [4:0]    waddr_o;

    memory_stage #(.CTRL_W(CW)) dut (
        .clk(clk), .resetn(resetn), .flush_i(fl), .valid_i(vi), .ready_o(ready_o),
        .pc_i(pc_in), .inst_i(inst_in), .ctrl_i(ctrl_in), .mem_rd_i(rd_in), .mem_wr_i(wr_in),
        .mem_size_i(size_in), .mem_lr_i(lr_in), .eaddr_i(ea_in), .rdata2_i(rt_in),
        .result_i(res_in), .waddr_i(wa_in), .data_req(data_req), .data_wr(data_wr),
        .data_size(data_size), .data_addr(data_addr), .data_wstrb(data_wstrb),
        .data_wdata(data_wdata), .data_addr_ok(aok), .ready_i(rdy), .valid_o(valid_o),
        .pc_o(pc_o), .inst_o(inst_o), .ctrl_o(ctrl_o), .eaddr_o(eaddr_o), .rdata2_o(rdata2_o),
        .result_o(result_o), .waddr_o(waddr_o), .adel_o(adel_o), .ades_o(ades_o),
        .perfcnt_addr_waitack(perf), .state_o(state_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: the single instruction held by the stage.
    logic          m_held, m_rd, m_wr, m_fault;
    logic [31:0]   m_pc, m_inst, m_ea, m_rt, m_res, m_perf;
    logic [CW-1:0] m_ctrl;
    logic [1:0]    m_size, m_lr;
    logic [4:0]    m_wa;
    logic [31:0]   exp_q[$];

    int          req_seen, vo_seen;
    logic [31:0] last_addr, last_wdata;
    logic [3:0]  last_strb;
    logic [1:0]  last_size;
    logic        last_adel;
    logic [CW-1:0] last_ctrl;

    task automatic clear_obs();
        req_seen = 0;
        vo_seen  = 0;
    endtask

    task automatic set_op(input logic rd, input logic wr, input logic [1:0] sz,
                          input logic [1:0] lr, input logic [31:0] ea, input logic [31:0] rt);
        vi = 1'b1; rd_in = rd; wr_in = wr; size_in = sz; lr_in = lr; ea_in = ea; rt_in = rt;
        pc_in = $urandom & 32'hffff_fffc; inst_in = $urandom; ctrl_in = CW'($urandom);
        res_in = $urandom; wa_in = 5'($urandom);
    endtask

    // Called at posedge+1 with inputs applied; checks mid-cycle, then advances one clock.
    task automatic cycle();
        logic        e_mem, e_req, e_vo, e_rdy;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_strb;
        logic [1:0]  e_size;
        int          oi;
        #2;
        e_mem = m_held && (m_rd || m_wr) && !m_fault;
        e_req = e_mem && rdy && !fl;
        e_vo  = m_held && !fl && (e_mem ? (e_req && aok) : 1'b1);
        e_rdy = !m_held || (e_vo && rdy);
        check("data_req", data_req, e_req);
        check("valid_o", valid_o, e_vo);
        check("ready_o", ready_o, e_rdy);
        check("perf", perf, m_perf);
        if (e_req) begin
            oi = int'(m_ea % 4);
            e_addr = (m_lr != 0) ? m_ea - 32'(oi) : m_ea;
            e_size = (m_lr != 0) ? 2'd2 : m_size;
            e_wdata = m_rt;
            if (!m_wr) e_strb = 4'h0;
            else if (m_lr == 1) begin
                e_strb = 4'((1 << (oi + 1)) - 1);
                e_wdata = m_rt >> (8 * (3 - oi));
            end else if (m_lr == 2) begin
                e_strb = 4'((15 << oi) & 15);
                e_wdata = m_rt << (8 * oi);
            end else if (m_size == 0) begin
                e_strb = 4'(1 << oi);
                e_wdata = (m_rt & 32'hff) * 32'h0101_0101;
            end else if (m_size == 1) begin
                e_strb = 4'(3 << oi);
                e_wdata = (m_rt & 32'hffff) * 32'h0001_0001;
            end else e_strb = 4'hf;
            check("data_wr", data_wr, m_wr);
            check("data_addr", data_addr, e_addr);
            check("data_size", data_size, e_size);
            check("data_wstrb", data_wstrb, e_strb);
            if (m_wr) check("data_wdata", data_wdata, e_wdata);
            req_seen++;
            last_addr = data_addr; last_wdata = data_wdata; last_strb = data_wstrb; last_size = data_size;
        end
        if (e_vo) begin
            check("inst_o", inst_o, m_inst);
            check("ctrl_o", ctrl_o, m_ctrl);
            check("eaddr_o", eaddr_o, m_ea);
            check("rdata2_o", rdata2_o, m_rt);
            check("result_o", result_o, m_res);
            check("waddr_o", waddr_o, m_wa);
            check("adel_o", adel_o, m_fault && m_rd);
            check("ades_o", ades_o, m_fault && m_wr);
            vo_seen++;
            last_adel = adel_o; last_ctrl = ctrl_o;
            if (rdy) check("handoff_pc", pc_o, exp_q.pop_front());
        end
        if (fl) begin
            if (m_held) void'(exp_q.pop_back());
            m_held = 1'b0;
        end else if (e_rdy) begin
            m_held = vi;
            if (vi) begin
                m_pc = pc_in; m_inst = inst_in; m_ctrl = ctrl_in; m_rd = rd_in; m_wr = wr_in;
                m_size = size_in; m_lr = lr_in; m_ea = ea_in; m_rt = rt_in; m_res = res_in; m_wa = wa_in;
                m_fault = (lr_in == 0) && (rd_in || wr_in) &&
                          ((size_in == 2 && ea_in % 4 != 0) || (size_in == 1 && ea_in % 2 != 0));
                exp_q.push_back(pc_in);
            end
        end
        if (e_req && !aok) m_perf = m_perf + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0; vi = 1'b0; fl = 1'b0; rdy = 1'b1; aok = 1'b0;
        @(posedge clk);
        #1;
        check("rst_valid_o", valid_o, 1'b0);
        check("rst_data_req", data_req, 1'b0);
        check("rst_ready_o", ready_o, 1'b1);
        check("rst_adel", adel_o, 1'b0);
        check("rst_ades", ades_o, 1'b0);
        check("rst_perf", perf, 32'd0);
        check("rst_pc_o", pc_o, 32'd0);
        check("rst_result_o", result_o, 32'd0);
        resetn = 1'b1;
        m_held = 1'b0; m_perf = '0;
        exp_q.delete();
    endtask

    initial begin
        resetn = 1'b0; fl = 1'b0; vi = 1'b0; rdy = 1'b1; aok = 1'b0;
        rd_in = 0; wr_in = 0; size_in = 0; lr_in = 0; ea_in = 0; rt_in = 0;
        pc_in = 0; inst_in = 0; ctrl_in = 0; res_in = 0; wa_in = 0;
        do_reset();

        // SW with two wait cycles before address acceptance
        clear_obs();
        set_op(1'b0, 1'b1, 2'd2, 2'b00, 32'h100, 32'hAABB_CCDD);
        cycle();
        vi = 1'b0;
        cycle(); cycle();
        aok = 1'b1; cycle();
        aok = 1'b0; cycle();
        check("sw_req_cycles", 32'(req_seen), 32'd3);
        check("sw_valid_cycles", 32'(vo_seen), 32'd1);
        check("sw_strb", last_strb, 4'hf);
        check("sw_perf", perf, 32'd2);

        // SB to the top byte lane
        set_op(1'b0, 1'b1, 2'd0, 2'b00, 32'h103, 32'h11);
        cycle();
        vi = 1'b0; aok = 1'b1; cycle();
        check("sb_addr", last_addr, 32'h103);
        check("sb_strb", last_strb, 4'b1000);
        check("sb_wdata", last_wdata, 32'h1111_1111);
        check("sb_size", last_size, 2'd0);

        // SWL at offset 1
        aok = 1'b0;
        set_op(1'b0, 1'b1, 2'd2, 2'b01, 32'h201, 32'h1234_5678);
        cycle();
        vi = 1'b0; aok = 1'b1; cycle();
        check("swl_addr", last_addr, 32'h200);
        check("swl_strb", last_strb, 4'b0011);
        check("swl_wdata", last_wdata, 32'h0000_1234);

        // Misaligned LW faults without touching the bus
        clear_obs(); aok = 1'b0;
        set_op(1'b1, 1'b0, 2'd2, 2'b00, 32'h102, 32'h0);
        ctrl_in = 16'h5A5A;
        cycle();
        vi = 1'b0; cycle();
        check("adel_req_cycles", 32'(req_seen), 32'd0);
        check("adel_valid_cycles", 32'(vo_seen), 32'd1);
        check("adel_flag", last_adel, 1'b1);
        check("adel_ctrl", last_ctrl, 16'h5A5A);

        // LW held back while WB is busy
        clear_obs();
        set_op(1'b1, 1'b0, 2'd2, 2'b00, 32'h100, 32'h0);
        cycle();
        vi = 1'b0; rdy = 1'b0;
        repeat (3) cycle();
        check("stall_req_cycles", 32'(req_seen), 32'd0);
        rdy = 1'b1; aok = 1'b1; cycle();
        check("stall_release_req", 32'(req_seen), 32'd1);
        check("stall_release_valid", 32'(vo_seen), 32'd1);

        // Flush while in REQ, with a new offer in the flush cycle
        clear_obs(); aok = 1'b0;
        set_op(1'b0, 1'b1, 2'd2, 2'b00, 32'h300, $urandom);
        cycle();
        set_op(1'b0, 1'b1, 2'd2, 2'b00, 32'h304, $urandom);
        fl = 1'b1; aok = 1'b1; cycle();
        vi = 1'b0; fl = 1'b0; cycle(); cycle();
        check("flush_req_cycles", 32'(req_seen), 32'd0);
        check("flush_valid_cycles", 32'(vo_seen), 32'd0);
        check("flush_empty", ready_o, 1'b1);

        // Reset while a request is pending
        aok = 1'b0; rdy = 1'b0;
        set_op(1'b0, 1'b1, 2'd2, 2'b00, 32'h400, $urandom);
        cycle();
        vi = 1'b0; cycle();
        do_reset();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            int kind;
            kind = $urandom_range(0, 5);
            set_op(kind == 2 || (kind == 4 && $urandom_range(0, 1) == 1), 1'b0,
                   2'($urandom_range(0, 2)), 2'b00, $urandom, $urandom);
            if (kind == 3) wr_in = 1'b1;
            if (kind == 4) begin
                wr_in = !rd_in;
                lr_in = 2'($urandom_range(1, 2));
                size_in = 2'd2;
            end
            vi  = $urandom_range(0, 1);
            fl  = ($urandom_range(0, 19) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            aok = ($urandom_range(0, 9) < 4);
            if ($urandom_range(0, 499) == 0) do_reset();
            else cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
